// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding-select unit: tracks the destinations of the last DEPTH
// issued instructions and derives per-source forwarding selects, load-use stalls and a stall counter.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic [REG_AW-1:0] id_dest,
    output logic              stall,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic [15:0]       stall_cycles
);

    // Shadow of downstream stages; index 0 is EXE, DEPTH-1 is the last stage before commit.
    logic              shd_v     [DEPTH];
    logic              shd_wreg  [DEPTH];
    logic              shd_m2reg [DEPTH];
    logic [REG_AW-1:0] shd_dest  [DEPTH];

    logic          hit_a, hit_b;
    logic [FW-1:0] k_a, k_b;
    logic          stall_a, stall_b;

    function automatic logic hit_at(input int k, input logic [REG_AW-1:0] src,
                                    input logic use_src);
        return id_valid && use_src && shd_v[k] && shd_wreg[k] &&
               (shd_dest[k] != '0) && (shd_dest[k] == src);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // ID-stage compare: scanning from oldest to youngest lets the youngest match overwrite.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        k_a   = '0;
        k_b   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_at(k, id_rs, id_use_rs)) begin
                hit_a = 1'b1;
                k_a   = FW'(k);
            end
            if (hit_at(k, id_rt, id_use_rt)) begin
                hit_b = 1'b1;
                k_b   = FW'(k);
            end
        end
    end

    always_comb begin
        if (FWD_EN != 0) begin
            stall_a = hit_a && (k_a == '0) && shd_m2reg[0];
            stall_b = hit_b && (k_b == '0) && shd_m2reg[0];
        end else begin
            stall_a = hit_a;
            stall_b = hit_b;
        end
        stall = stall_a || stall_b;
        fwd_a = (stall || (FWD_EN == 0) || !hit_a) ? '0 : k_a + FW'(1);
        fwd_b = (stall || (FWD_EN == 0) || !hit_b) ? '0 : k_b + FW'(1);
    end

    // Shadow advance, control half: valid bits and the stall counter honour reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                shd_v[k] <= 1'b0;
            end
            stall_cycles <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                shd_v[k] <= shd_v[k-1];
            end
            shd_v[0] <= id_valid && !stall;
            if (stall) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
        end
    end

    // Shadow advance, data half: fields are qualified by the valid bit, so no reset needed.
    always_ff @(posedge clock) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
            shd_wreg[k]  <= shd_wreg[k-1];
            shd_m2reg[k] <= shd_m2reg[k-1];
            shd_dest[k]  <= shd_dest[k-1];
        end
        if (id_valid && !stall) begin
            shd_wreg[0]  <= id_wreg;
            shd_m2reg[0] <= id_m2reg;
            shd_dest[0]  <= id_dest;
        end else begin
            shd_wreg[0]  <= 1'b0;
            shd_m2reg[0] <= 1'b0;
            shd_dest[0]  <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: three configurations share the ID inputs, a
// history-list reference model predicts each cycle, and a negedge monitor compares.
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wreg = 1'b0, id_m2reg = 1'b0;

    logic        st0, st1, st2;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [2:0]  fa2, fb2;
    logic [15:0] c0, c1, c2;

    always #5 clock = ~clock;

    hazard_scoreboard u0 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_dest(id_dest), .stall(st0), .fwd_a(fa0), .fwd_b(fb0), .stall_cycles(c0));

    hazard_scoreboard #(.DEPTH(2), .FWD_EN(0)) u1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_dest(id_dest), .stall(st1), .fwd_a(fa1), .fwd_b(fb1), .stall_cycles(c1));

    hazard_scoreboard #(.DEPTH(7), .FWD_EN(0)) u2 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
        .id_dest(id_dest), .stall(st2), .fwd_a(fa2), .fwd_b(fb2), .stall_cycles(c2));

    typedef struct packed {
        logic       v;
        logic       wreg;
        logic       m2reg;
        logic [4:0] dest;
    } ent_t;

    typedef struct {
        logic        chk;
        logic        st  [3];
        logic [2:0]  fa  [3];
        logic [2:0]  fb  [3];
        logic [15:0] cnt [3];
    } exp_t;

    // Issue history per configuration, most recent first; only the first dep[i] are visible.
    ent_t hist [3][8];
    int   dep  [3];
    bit   fe   [3];
    int   mcnt [3];
    exp_t expq [$];
    int   checks = 0;
    int   errors = 0;

    function automatic void youngest(input int i, input logic [4:0] src, input logic use_s,
                                     output logic hit, output int k);
        hit = 1'b0;
        k   = 0;
        for (int j = 0; j < 8; j++) begin
            if (!hit && j < dep[i] && id_valid && use_s && src != 5'd0 &&
                hist[i][j].v && hist[i][j].wreg && hist[i][j].dest == src) begin
                hit = 1'b1;
                k   = j;
            end
        end
    endfunction

    task automatic step(input logic rst, input logic vld, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic wr, input logic m2,
                        input logic [4:0] dst, input logic chk);
        exp_t e;
        logic ha, hb, s;
        int   ka, kb;
        reset = rst; id_valid = vld; id_rs = rs; id_rt = rt; id_use_rs = urs;
        id_use_rt = urt; id_wreg = wr; id_m2reg = m2; id_dest = dst;
        e.chk = chk;
        for (int i = 0; i < 3; i++) begin
            youngest(i, rs, urs, ha, ka);
            youngest(i, rt, urt, hb, kb);
            if (fe[i])
                s = (ha && ka == 0 && hist[i][0].m2reg) || (hb && kb == 0 && hist[i][0].m2reg);
            else
                s = ha || hb;
            e.st[i]  = s;
            e.fa[i]  = (fe[i] && !s && ha) ? 3'(ka + 1) : 3'd0;
            e.fb[i]  = (fe[i] && !s && hb) ? 3'(kb + 1) : 3'd0;
            e.cnt[i] = 16'(mcnt[i]);
            if (rst) begin
                for (int j = 0; j < 8; j++) hist[i][j] = '0;
                mcnt[i] = 0;
            end else begin
                if (s && mcnt[i] < 65535) mcnt[i]++;
                for (int j = 7; j >= 1; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = (vld && !s) ? {1'b1, wr, m2, dst} : ent_t'(0);
            end
        end
        expq.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic wr, input logic m2, input logic [4:0] dst);
        step(1'b0, 1'b1, rs, rt, urs, urt, wr, m2, dst, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic cmp(input string nm, input int i, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s[u%0d] actual %h required %h at %0t", nm, i, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.chk) begin
                cmp("stall", 0, {15'd0, st0}, {15'd0, e.st[0]});
                cmp("fwd_a", 0, {14'd0, fa0}, {13'd0, e.fa[0]});
                cmp("fwd_b", 0, {14'd0, fb0}, {13'd0, e.fb[0]});
                cmp("stall_cycles", 0, c0, e.cnt[0]);
                cmp("stall", 1, {15'd0, st1}, {15'd0, e.st[1]});
                cmp("fwd_a", 1, {14'd0, fa1}, {13'd0, e.fa[1]});
                cmp("fwd_b", 1, {14'd0, fb1}, {13'd0, e.fb[1]});
                cmp("stall_cycles", 1, c1, e.cnt[1]);
                cmp("stall", 2, {15'd0, st2}, {15'd0, e.st[2]});
                cmp("fwd_a", 2, {13'd0, fa2}, {13'd0, e.fa[2]});
                cmp("fwd_b", 2, {13'd0, fb2}, {13'd0, e.fb[2]});
                cmp("stall_cycles", 2, c2, e.cnt[2]);
            end
        end
    end

    initial begin
        dep[0] = 3; dep[1] = 2; dep[2] = 7;
        fe[0]  = 1'b1; fe[1] = 1'b0; fe[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            for (int j = 0; j < 8; j++) hist[i][j] = '0;
        end
        @(posedge clock);
        #1;
        do_reset();

        // add $3,$1,$2 ; sub $4,$9,$3 ; or $5,$3,$9
        ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        ins(5'd9, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        ins(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        do_reset();

        // lw $3,0($0) ; add $5,$3,$9 held across the load-use bubble
        ins(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
        ins(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        ins(5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        ins(5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        do_reset();

        // two writers of $3, then sub $4,$3,$3
        ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        ins(5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        ins(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        do_reset();

        // writes to $0 never match; a masked rt never matches
        ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        ins(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        ins(5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        ins(5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9);
        do_reset();

        // RAW in stall-only mode drains over the tracked depth
        ins(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);
        for (int n = 0; n < 8; n++) ins(5'd9, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'b1);
        end
        do_reset();

        // Self-dependent instruction keeps the DEPTH=7 stall-only counter busy until it saturates
        for (int n = 0; n < 75200; n++) ins(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1);
        for (int n = 0; n < 4; n++) ins(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);

        @(negedge clock);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d required 0 pending entries", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
